// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic [1:0] {
    PC_RESET = 2'd0,
    PC_TRAP  = 2'd1,
    PC_EPC   = 2'd2,
    PC_NEXT  = 2'd3
  } pc_source_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAKE = 2'd2,
    RET  = 2'd3
  } trap_state_t;

  localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
  localparam logic [4:0] CAUSE_TIMER    = 5'd7;
  localparam logic [4:0] CAUSE_EXT_BASE = 5'd8;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over N request lines.
module irq_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set line is the last to overwrite idx.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl_mc.sv
// Machine-mode trap controller: prioritised interrupts/exceptions, trap PC, handler lock.
// Optional TRAP_VECTORED_EN adds vectored interrupt targets (base + 4*code) for mtvec mode 1.
module trap_ctrl_mc
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int XLEN    = 32,
  parameter int ID_W    = $clog2(NUM_IRQ + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_insn_vld,
  input  logic               i_mret,
  input  logic [NUM_IRQ-1:0] i_ext_irq,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_tmr_irq,
  input  logic               i_mie,
  input  logic               i_meie,
  input  logic               i_mtie,
  input  logic [XLEN-1:0]    i_mtvec,
  output pc_source_t         o_pc_src,
  output logic [XLEN-1:0]    o_trap_pc,
  output logic               o_trap_take,
  output logic               o_mret_take,
  output logic               o_flush,
  output logic               o_cause_int,
  output logic [4:0]         o_cause_code,
  output logic [ID_W-1:0]    o_claim_id,
  output logic               o_in_handler
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_t        state;
  trap_state_t        state_next;
  logic               in_handler;
  logic               irq_ok;
  logic [NUM_IRQ-1:0] ext_pend;
  logic               ext_found;
  logic [IDX_W-1:0]   ext_idx;
  logic               tmr_pend;
  logic               exc_pend;
  logic               trap_pend;
  logic               take_enter;
  logic               ret_enter;
  logic               cause_int_next;
  logic [4:0]         cause_code_next;
  logic [ID_W-1:0]    claim_next;
  logic [XLEN-1:0]    base;
  logic [XLEN-1:0]    trap_pc_next;

  // in_handler masks interrupts only; illegal instructions still trap inside a handler.
  assign irq_ok    = i_mie & ~in_handler;
  assign ext_pend  = i_ext_irq & i_irq_mask & {NUM_IRQ{i_meie & irq_ok}};
  assign tmr_pend  = i_tmr_irq & i_mtie & irq_ok;
  assign exc_pend  = ~i_insn_vld;
  assign trap_pend = ext_found | tmr_pend | exc_pend;

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (ext_pend),
    .found (ext_found),
    .idx   (ext_idx)
  );

  always_comb begin
    cause_int_next  = 1'b0;
    cause_code_next = CAUSE_ILLEGAL;
    claim_next      = '0;
    if (ext_found) begin
      cause_int_next  = 1'b1;
      cause_code_next = CAUSE_EXT_BASE + 5'(ext_idx);
      claim_next      = ID_W'(ext_idx) + ID_W'(1);
    end else if (tmr_pend) begin
      cause_int_next  = 1'b1;
      cause_code_next = CAUSE_TIMER;
    end
  end

  assign base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign trap_pc_next = (cause_int_next && (i_mtvec[1:0] == MTVEC_VECTORED))
                        ? base + XLEN'({cause_code_next, 2'b00})
                        : base;
`else
  logic unused_mode;
  assign unused_mode  = ^i_mtvec[1:0];
  assign trap_pc_next = base;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    o_pc_src    = PC_NEXT;
    o_flush     = 1'b0;
    o_trap_take = 1'b0;
    o_mret_take = 1'b0;
    case (state)
      IDLE: begin
        state_next = RUN;
        o_pc_src   = PC_RESET;
        o_flush    = 1'b1;
      end
      RUN: begin
        if (trap_pend)   state_next = TAKE;
        else if (i_mret) state_next = RET;
      end
      TAKE: begin
        state_next  = RUN;
        o_pc_src    = PC_TRAP;
        o_trap_take = 1'b1;
        o_flush     = 1'b1;
      end
      RET: begin
        state_next  = RUN;
        o_pc_src    = PC_EPC;
        o_mret_take = 1'b1;
        o_flush     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // A trap outranks a simultaneous mret; the dropped mret is refetched after return.
  assign take_enter = (state == RUN) && trap_pend;
  assign ret_enter  = (state == RUN) && !trap_pend && i_mret;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_handler   <= 1'b0;
      o_cause_int  <= 1'b0;
      o_cause_code <= '0;
      o_claim_id   <= '0;
      o_trap_pc    <= '0;
    end else if (take_enter) begin
      in_handler   <= 1'b1;
      o_cause_int  <= cause_int_next;
      o_cause_code <= cause_code_next;
      o_claim_id   <= claim_next;
      o_trap_pc    <= trap_pc_next;
    end else if (ret_enter) begin
      in_handler   <= 1'b0;
    end
  end

  assign o_in_handler = in_handler;

endmodule
